ghash_acc: RTL and testbench

GHASH_ACC -- requirements
Module: ghash_acc

---
 rtl/ghash_acc_pkg.sv | 17 +
 rtl/ghash_acc_if.sv | 28 ++
 rtl/ghash_acc_gfm.sv | 79 +++++++
 rtl/ghash_acc.sv | 115 +++++++++++
 tb/tb_ghash_acc.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ghash_acc_pkg.sv
// Shared GCM definitions: field width, default reduction polynomial and the
// accumulator state encoding.
package ghash_acc_pkg;

  localparam int GCM_BITS = 128;

  // x^128 + x^7 + x^2 + x + 1
  localparam logic [GCM_BITS:0] GCM_POLY = 129'h1_0000_0000_0000_0000_0000_0000_0000_0087;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    MUL    = 2'd2,
    OUT    = 2'd3
  } ghash_state_e;

endpackage

// File: rtl/ghash_acc_if.sv
// Key load, block input and tag output handshakes of the GHASH accumulator.
interface ghash_acc_if
  import ghash_acc_pkg::*;
#(
  parameter int BITS = GCM_BITS
);

  logic            key_valid;
  logic [BITS-1:0] key;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_tag;

  modport master (
    output key_valid, key, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_tag
  );

  modport slave (
    input  key_valid, key, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_tag
  );

endinterface

// File: rtl/ghash_acc_gfm.sv
// Iterative GF(2^n) multiplier, MSB-first shift-and-add over GFM_CYCLES cycles.
// done pulses GFM_CYCLES cycles after en is sampled; en is ignored while busy.
module gfm
  import ghash_acc_pkg::*;
#(
  parameter int                  GFM_BITS   = GCM_BITS,
  parameter int                  GFM_CYCLES = 8,
  parameter logic [GFM_BITS:0]   POLYNOMIAL = GCM_POLY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [GFM_BITS-1:0] a,
  input  logic [GFM_BITS-1:0] b,
  output logic [GFM_BITS-1:0] result,
  output logic                done
);

  localparam int STEP = GFM_BITS / GFM_CYCLES;
  localparam int CW   = $clog2(GFM_CYCLES + 1);

  logic [GFM_BITS-1:0] r_a;
  logic [GFM_BITS-1:0] r_b;
  logic [GFM_BITS-1:0] r_acc;
  logic [GFM_BITS-1:0] r_result;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_done;

  logic [GFM_BITS-1:0] w_acc;
  logic [GFM_BITS-1:0] w_b;

  // Horner step per bit of b: acc = acc*x mod P, then add a when the bit is set.
  always_comb begin
    w_acc = r_acc;
    w_b   = r_b;
    for (int i = 0; i < STEP; i++) begin
      w_acc = {w_acc[GFM_BITS-2:0], 1'b0} ^ (w_acc[GFM_BITS-1] ? POLYNOMIAL[GFM_BITS-1:0] : '0);
      if (w_b[GFM_BITS-1]) begin
        w_acc = w_acc ^ r_a;
      end
      w_b = {w_b[GFM_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (en && !r_busy) begin
        r_a    <= a;
        r_b    <= b;
        r_acc  <= '0;
        r_cnt  <= CW'(GFM_CYCLES);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_acc <= w_acc;
        r_b   <= w_b;
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy   <= 1'b0;
          r_result <= w_acc;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign result = r_result;
  assign done   = r_done;

endmodule

// File: rtl/ghash_acc.sv
// GHASH accumulator: Y <= (Y ^ X) * H per accepted block, tag presented after the last block.
//   state  | meaning
//   IDLE   | no key since reset; waiting for key_valid
//   ACCEPT | in_ready high; key reload or block handshake
//   MUL    | multiply outstanding; waiting for gfm done
//   OUT    | tag held on out_tag until out_ready
module ghash_acc
  import ghash_acc_pkg::*;
#(
  parameter int                GFM_BITS   = GCM_BITS,
  parameter int                GFM_CYCLES = 8,
  parameter logic [GFM_BITS:0] POLYNOMIAL = GCM_POLY
) (
  input  logic        clk,
  input  logic        reset,
  ghash_acc_if.slave  bus
);

  ghash_state_e        r_state;
  logic [GFM_BITS-1:0] r_h;
  logic [GFM_BITS-1:0] r_y;
  logic                r_last;
  logic                r_gfm_en;
  logic [GFM_BITS-1:0] r_gfm_a;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [GFM_BITS-1:0] r_out_tag;

  logic                w_gfm_reset;
  logic [GFM_BITS-1:0] w_gfm_result;
  logic                w_gfm_done;

  assign w_gfm_reset = ~reset;

  gfm #(
    .GFM_BITS   (GFM_BITS),
    .GFM_CYCLES (GFM_CYCLES),
    .POLYNOMIAL (POLYNOMIAL)
  ) u_gfm (
    .clk    (clk),
    .reset  (w_gfm_reset),
    .en     (r_gfm_en),
    .a      (r_gfm_a),
    .b      (r_h),
    .result (w_gfm_result),
    .done   (w_gfm_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_h         <= '0;
      r_y         <= '0;
      r_last      <= 1'b0;
      r_gfm_en    <= 1'b0;
      r_gfm_a     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_tag   <= '0;
    end else begin
      r_gfm_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.key_valid) begin
            r_h        <= bus.key;
            r_y        <= '0;
            r_in_ready <= 1'b1;
            r_state    <= ACCEPT;
          end
        end
        ACCEPT: begin
          // A key load takes precedence over a block offered in the same cycle.
          if (bus.key_valid) begin
            r_h <= bus.key;
            r_y <= '0;
          end else if (bus.in_valid) begin
            r_last     <= bus.in_last;
            r_gfm_a    <= r_y ^ bus.in_data;
            r_gfm_en   <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= MUL;
          end
        end
        MUL: begin
          if (w_gfm_done) begin
            r_y <= w_gfm_result;
            if (r_last) begin
              r_out_tag   <= w_gfm_result;
              r_out_valid <= 1'b1;
              r_state     <= OUT;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= ACCEPT;
            end
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            r_y         <= '0;
            r_last      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ACCEPT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_tag   = r_out_tag;

endmodule

// File: tb/tb_ghash_acc.sv
// Directed bench for ghash_acc: hand-computed GF(2^128) tags, handshake timing and reset abort.
module tb_ghash_acc;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ghash_acc_if #(.BITS(128)) bus ();

  ghash_acc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam int LAT = 10;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key       = k;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  // Offer a block, then measure cycles until in_ready or out_valid returns.
  task automatic send_block(input string tag, input logic [127:0] d, input logic last,
                            input logic poke_key);
    int waitc;
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    waitc = 0;
    while (!bus.in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.in_ready) begin
      chk({tag, "_ready_timeout"}, 128'(bus.in_ready), 128'(1'b1));
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (poke_key) begin
      bus.key_valid = 1'b1;
      bus.key       = 128'h2;
    end
    lat = 0;
    while (!bus.in_ready && !bus.out_valid && lat < 40) begin
      lat++;
      @(negedge clk);
      bus.key_valid = 1'b0;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(LAT));
    chk({tag, "_rdy_vld"}, 128'({bus.in_ready, bus.out_valid}), 128'({!last, last}));
  endtask

  task automatic take_tag(input string tag, input logic [127:0] exp, input int hold);
    int  w;
    logic stable;
    w = 0;
    while (!bus.out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_valid"}, 128'(bus.out_valid), 128'(1'b1));
    chk(tag, bus.out_tag, exp);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_tag !== exp || bus.in_ready !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) chk({tag, "_hold"}, 128'(stable), 128'(1'b1));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_release"}, 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key_valid = 1'b0;
    bus.key       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    reset         = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1'b0));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("rst_out_tag", bus.out_tag, 128'h0);
    reset = 1'b1;

    // Blocks offered without a key are never accepted.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 128'h1;
    repeat (3) @(negedge clk);
    chk("nokey_in_ready", 128'(bus.in_ready), 128'(1'b0));
    bus.in_valid = 1'b0;

    // H = 1: tag is the xor of all blocks.
    load_key(128'h1);
    send_block("m1_b0", 128'h11, 1'b0, 1'b0);
    send_block("m1_b1", 128'h22, 1'b0, 1'b0);
    send_block("m1_b2", 128'h44, 1'b1, 1'b0);
    take_tag("m1_tag", 128'h77, 0);

    // H = 0 gives zero, then a fresh message under H = 1 with a long stall.
    load_key(128'h0);
    send_block("m2_b0", 128'hdead, 1'b0, 1'b0);
    send_block("m2_b1", 128'hbeef, 1'b0, 1'b0);
    send_block("m2_b2", 128'h1234, 1'b1, 1'b0);
    take_tag("m2_tag", 128'h0, 0);
    load_key(128'h1);
    send_block("m3_b0", 128'hA5, 1'b1, 1'b0);
    take_tag("m3_tag", 128'hA5, 10);

    // Reference vector.
    load_key(128'h48692853686179295b477565726f6e5d);
    send_block("m4_b0", 128'h7b5b54657374566563746f725d53475d, 1'b1, 1'b0);
    take_tag("m4_tag", 128'h040229a09a5ed12e7e4e10da323506d2, 0);

    // x^127 * x = x^128 = x^7 + x^2 + x + 1.
    load_key(128'h2);
    send_block("m5_b0", 128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b1, 1'b0);
    take_tag("m5_tag", 128'h87, 0);

    // key_valid during MUL and OUT is ignored; H survives the tag handshake.
    load_key(128'h1);
    send_block("m6_b0", 128'h3, 1'b0, 1'b1);
    send_block("m6_b1", 128'h0, 1'b1, 1'b0);
    bus.key_valid = 1'b1;
    bus.key       = 128'h2;
    @(negedge clk);
    bus.key_valid = 1'b0;
    take_tag("m6_tag", 128'h3, 0);
    send_block("m7_b0", 128'h9, 1'b1, 1'b0);
    take_tag("m7_tag", 128'h9, 0);

    // Key load colliding with in_valid: block dropped, Y cleared, new H used.
    load_key(128'h1);
    send_block("m8_b0", 128'h11, 1'b0, 1'b0);
    bus.key_valid = 1'b1;
    bus.key       = 128'h2;
    bus.in_valid  = 1'b1;
    bus.in_data   = 128'h33;
    bus.in_last   = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    chk("m8_collide_ready", 128'(bus.in_ready), 128'(1'b1));
    send_block("m8_b1", 128'h5, 1'b1, 1'b0);
    take_tag("m8_tag", 128'hA, 0);

    // Reset in the middle of a final-block multiply.
    load_key(128'h1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 128'h77;
    bus.in_last  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_out_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("abort_in_ready", 128'(bus.in_ready), 128'(1'b0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort_quiet", 128'({bus.out_valid, bus.in_ready}), 128'(2'b00));
    load_key(128'h1);
    send_block("m9_b0", 128'h5, 1'b1, 1'b0);
    take_tag("m9_tag", 128'h5, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
